cordic_cos_fx: RTL and testbench



---
 rtl/cordic_cos_fx.sv | 167 ++++++++++++++++
 tb/tb_cordic_cos_fx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cordic_cos_fx.sv
// Iterative CORDIC cosine, signed Q2.22 in/out, start/done with clock enable.
// Define CORDIC_SIN_EN to also register sin(angle) on result_sin.
module cordic_cos_fx #(
   parameter int ITER  = 22,
   parameter int GUARD = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic        start,
   input  logic [23:0] angle,
   output logic        busy,
   output logic        done,
   output logic [23:0] result
`ifdef CORDIC_SIN_EN
   ,
   output logic [23:0] result_sin
`endif
);

   localparam int W   = 24 + GUARD;
   localparam int IW  = $clog2(ITER);
   localparam int RND = 1 << (GUARD - 1);
   localparam logic [IW-1:0] LAST = IW'(ITER - 1);
   localparam logic signed [23:0] A_MAX = 24'sh400000;
   localparam logic signed [23:0] A_MIN = 24'shC00000;
   localparam logic signed [W-1:0] K_INIT = {24'h26DD3B, {GUARD{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef logic [ITER-1:0][W-1:0] lut_t;

   // atan(2^-n) via its power series at 2^60 scale, then rounded to 22+GUARD bits
   function automatic logic [W-1:0] atan_entry(input int n);
      logic [63:0] acc;
      logic [63:0] t;
      int          e;
      acc = 64'd0;
      if (n == 0) begin
         acc = 64'h0C90FDAA22168C23;
      end else begin
         for (int k = 0; k < 32; k++) begin
            e = n * (2 * k + 1);
            if (e <= 60) begin
               t = (64'd1 << (60 - e)) / 64'(2 * k + 1);
               if (k % 2 == 1) acc = acc - t;
               else            acc = acc + t;
            end
         end
      end
      return W'((acc + (64'd1 << (37 - GUARD))) >> (38 - GUARD));
   endfunction

   function automatic lut_t build_lut();
      lut_t l;
      for (int n = 0; n < ITER; n++) l[n] = atan_entry(n);
      return l;
   endfunction

   localparam lut_t ATAN_LUT = build_lut();

   function automatic logic [23:0] sat_rnd(input logic signed [W-1:0] v);
      logic signed [W:0] s;
      s = ($signed({v[W-1], v}) + (W+1)'(RND)) >>> GUARD;
      if (!s[W] && (|s[W-1:23])) return 24'h7FFFFF;
      if (s[W] && !(&s[W-1:23])) return 24'h800000;
      return s[23:0];
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic signed [W-1:0]   r_x;
   logic signed [W-1:0]   r_y;
   logic signed [W-1:0]   r_z;
   logic [IW-1:0]         r_i;
   logic                  r_done;
   logic [23:0]           r_result;
   logic signed [23:0]    w_clamp;
   logic signed [W-1:0]   w_xs;
   logic signed [W-1:0]   w_ys;
   logic signed [W-1:0]   w_atan;
   logic                  w_neg;
`ifdef CORDIC_SIN_EN
   logic [23:0]           r_sin;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_state <= S_IDLE;
      else if (clk_en) r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_i == LAST) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN);
   end

   always_comb begin
      w_clamp = $signed(angle);
      if ($signed(angle) > A_MAX)      w_clamp = A_MAX;
      else if ($signed(angle) < A_MIN) w_clamp = A_MIN;
   end

   assign w_xs   = r_x >>> r_i;
   assign w_ys   = r_y >>> r_i;
   assign w_atan = $signed(ATAN_LUT[r_i]);
   assign w_neg  = r_z[W-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_i      <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
`ifdef CORDIC_SIN_EN
         r_sin    <= '0;
`endif
      end else if (clk_en) begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x <= K_INIT;
                  r_y <= '0;
                  r_z <= {w_clamp, {GUARD{1'b0}}};
                  r_i <= '0;
               end
            end
            S_RUN: begin
               r_x <= w_neg ? r_x + w_ys : r_x - w_ys;
               r_y <= w_neg ? r_y - w_xs : r_y + w_xs;
               r_z <= w_neg ? r_z + w_atan : r_z - w_atan;
               r_i <= r_i + IW'(1);
            end
            S_DONE: begin
               r_result <= sat_rnd(r_x);
               r_done   <= 1'b1;
`ifdef CORDIC_SIN_EN
               r_sin    <= sat_rnd(r_y);
`endif
            end
            default: ;
         endcase
      end
   end

   assign done   = r_done;
   assign result = r_result;
`ifdef CORDIC_SIN_EN
   assign result_sin = r_sin;
`endif

endmodule

// File: tb/tb_cordic_cos_fx.sv
// Directed + randomized bench for cordic_cos_fx against a real-math cos/sin model.
module tb_cordic_cos_fx;

   localparam int ITER = 22;
   localparam int TOL  = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_en;
   logic        start;
   logic [23:0] angle;
   logic        busy;
   logic        done;
   logic [23:0] result;
`ifdef CORDIC_SIN_EN
   logic [23:0] result_sin;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   cordic_cos_fx dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .start   (start),
      .angle   (angle),
      .busy    (busy),
      .done    (done),
`ifdef CORDIC_SIN_EN
      .result_sin (result_sin),
`endif
      .result  (result)
   );

   always #5 clk = ~clk;

   function automatic int ref_val(input logic [23:0] a, input bit want_sin);
      int  v;
      real r;
      v = int'($signed(a));
      if (v > 32'sh400000)  v = 32'sh400000;
      if (v < -32'sh400000) v = -32'sh400000;
      r = real'(v) / 4194304.0;
      r = want_sin ? $sin(r) : $cos(r);
      return int'($floor(r * 4194304.0 + 0.5));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_tol(input string tag, input logic [23:0] obs,
                          input int exp);
      int d;
      logic ok;
      n_chk++;
      d  = int'($signed(obs)) - exp;
      ok = !$isunknown(obs) && d <= TOL && d >= -TOL;
      assert (ok === 1'b1) n_pass++;
      else $error("FAIL %s: got %06h expected %06h +-%0d", tag, obs,
                  exp[23:0], TOL);
   endtask

   // Called at a negedge; returns at the negedge where done is first seen.
   task automatic run_op(input logic [23:0] a, input int stall);
      int k;
      int p;
      p = $urandom_range(3, 15);
      start = 1'b1;
      angle = a;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         if (stall > 0 && k == p)         clk_en = 1'b0;
         if (stall > 0 && k == p + stall) clk_en = 1'b1;
         start = (busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
         angle = 24'($urandom);
         @(negedge clk);
         k++;
      end
      start  = 1'b0;
      clk_en = 1'b1;
      chk("latency", 32'(k), 32'(ITER + 1 + stall));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk_tol("cos", result, ref_val(a, 1'b0));
`ifdef CORDIC_SIN_EN
      chk_tol("sin", result_sin, ref_val(a, 1'b1));
`endif
   endtask

   initial begin
      logic [23:0] held;
      logic        seen;

      reset_n = 1'b0;
      clk_en  = 1'b1;
      start   = 1'b1;
      angle   = 24'h300000;
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      start   = 1'b0;
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);

      run_op(24'h300000, 0);
      run_op(24'h000000, 0);
      run_op(24'hD00000, 0);
      run_op(24'h7FFFFF, 0);
      run_op(24'h400000, 0);
      run_op(24'h800000, 0);

      held   = result;
      clk_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
      chk("result_hold", 32'(result), 32'(held));
      clk_en = 1'b1;
      @(negedge clk);
      chk("done_clear", 32'(done), 32'd0);
      chk("result_keep", 32'(result), 32'(held));
      @(negedge clk);

      run_op(24'h300000, 5);
      @(negedge clk);

      for (int n = 0; n < 16; n++) begin
         run_op(24'($urandom), (n % 3 == 0) ? 0 : int'($urandom_range(1, 6)));
         if (n % 2 == 0) @(negedge clk);
      end

      @(negedge clk);
      start = 1'b1;
      angle = 24'h300000;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk("no_stale_done", 32'(seen), 32'd0);
      run_op(24'h300000, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
